// File: rtl/frame_fifo_if.sv
// Stream-side signal bundle for frame_fifo: byte write port from the MAC
// receive path, byte read port toward the transmit controller, and the
// frame/level status seen by the flow-control logic.
interface frame_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11,
    parameter int LQ_W   = 4
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_last;
    logic              wr_bad;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic [15:0]       frm_len;
    logic              frm_avail;
    logic [LQ_W:0]     frm_count;
    logic [ADDR_W:0]   used;
    logic              pause_req;
    logic              drop_pulse;
    logic [15:0]       drop_count;

    // Producer/consumer side: drives the write stream and the read handshake.
    modport master (
        output wr_data, wr_valid, wr_last, wr_bad, rd_ready,
        input  rd_data, rd_valid, rd_last, frm_len, frm_avail, frm_count,
               used, pause_req, drop_pulse, drop_count
    );

    // FIFO side.
    modport slave (
        input  wr_data, wr_valid, wr_last, wr_bad, rd_ready,
        output rd_data, rd_valid, rd_last, frm_len, frm_avail, frm_count,
               used, pause_req, drop_pulse, drop_count
    );
endinterface

// File: rtl/frame_fifo.sv
// Frame-aware store-and-forward byte FIFO. Bytes are written speculatively
// and only become visible to the reader once the frame ends cleanly; bad,
// overflowing, over-long or too-short frames are rewound. A small length
// queue presents each frame's length before its first byte is read.
module frame_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 11,
    parameter int LQ_W      = 4,
    parameter int STRIP_FCS = 1,
    parameter int PAUSE_HI  = 1536,
    parameter int PAUSE_LO  = 512
) (
    input  logic        clk,
    input  logic        rst,
    frame_fifo_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, STREAM} rd_state_t;

    localparam logic [ADDR_W:0] PTR_ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FULL_LVL     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PAUSE_HI_LVL = (ADDR_W+1)'(PAUSE_HI);
    localparam logic [ADDR_W:0] PAUSE_LO_LVL = (ADDR_W+1)'(PAUSE_LO);
    // On the final byte the reader also skips the stored-but-hidden FCS.
    localparam logic [ADDR_W:0] POP_STEP     = (STRIP_FCS != 0) ? (ADDR_W+1)'(5) : (ADDR_W+1)'(1);
    localparam logic [15:0]     FCS_LEN      = (STRIP_FCS != 0) ? 16'd4 : 16'd0;
    localparam logic [LQ_W-1:0] LQ_ONE       = LQ_W'(1);

    logic [DATA_W-1:0] mem    [0:(1<<ADDR_W)-1];
    logic [15:0]       lq_mem [0:(1<<LQ_W)-1];

    logic [ADDR_W:0]   wr_ptr_reg, cmt_ptr_reg, rd_ptr_reg;
    logic [16:0]       cur_len_reg;
    logic              ovf_reg;
    logic [LQ_W-1:0]   lq_wr_reg, lq_rd_reg;
    logic [LQ_W:0]     frm_count_reg;
    logic [15:0]       drop_count_reg;
    logic              drop_pulse_reg;
    logic              pause_reg;
    logic [15:0]       rem_reg;
    logic [DATA_W-1:0] rd_data_reg;
    rd_state_t         state_reg, state_next;

    logic [ADDR_W:0]   used_w, wr_ptr_adv, rd_ptr_plus1;
    logic              full_w, byte_ok, ovf_now, frame_end, drop_w, commit_w;
    logic              too_long, too_short;
    logic [16:0]       stored_len;
    logic [15:0]       frm_len_w;
    logic              accept, last_beat, pop_w, rd_valid_w, rd_last_w, ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;

    // Write-side decisions: byte acceptance and the end-of-frame verdict.
    assign used_w     = wr_ptr_reg - rd_ptr_reg;
    assign full_w     = (used_w == FULL_LVL);
    assign byte_ok    = bus.wr_valid && !full_w && !ovf_reg;
    assign ovf_now    = ovf_reg || (bus.wr_valid && full_w);
    assign wr_ptr_adv = byte_ok ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
    assign stored_len = cur_len_reg + 17'(byte_ok);
    assign frame_end  = bus.wr_valid && bus.wr_last;
    assign too_long   = (cur_len_reg >= 17'd65535);
    assign too_short  = (STRIP_FCS != 0) && (stored_len <= 17'd4);
    assign drop_w     = frame_end && (ovf_now || bus.wr_bad || frm_count_reg[LQ_W] || too_long || too_short);
    assign commit_w   = frame_end && !drop_w;

    assign rd_ptr_plus1 = rd_ptr_reg + PTR_ONE;
    assign frm_len_w    = (frm_count_reg != '0) ? (lq_mem[lq_rd_reg] - FCS_LEN) : 16'd0;

    // Read FSM next state, handshake outputs and RAM read control.
    always_comb begin
        state_next = state_reg;
        rd_valid_w = 1'b0;
        rd_last_w  = 1'b0;
        accept     = 1'b0;
        last_beat  = (rem_reg == 16'd1);
        pop_w      = 1'b0;
        ram_rd_en  = 1'b0;
        ram_addr   = rd_ptr_reg[ADDR_W-1:0];
        case (state_reg)
            IDLE: begin
                if (frm_count_reg != '0) state_next = LOAD;
            end
            LOAD: begin
                ram_rd_en  = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                rd_valid_w = 1'b1;
                rd_last_w  = last_beat;
                accept     = bus.rd_ready;
                pop_w      = bus.rd_ready && last_beat;
                // Pre-advance so the next byte is registered on the accept edge.
                ram_rd_en  = bus.rd_ready;
                ram_addr   = rd_ptr_plus1[ADDR_W-1:0];
                if (pop_w) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Data RAM write port.
    always_ff @(posedge clk) begin
        if (byte_ok) mem[wr_ptr_reg[ADDR_W-1:0]] <= bus.wr_data;
    end

    // Data RAM registered read; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_reg <= '0;
        else if (ram_rd_en) rd_data_reg <= mem[ram_addr];
    end

    // Length queue storage.
    always_ff @(posedge clk) begin
        if (commit_w) lq_mem[lq_wr_reg] <= stored_len[15:0];
    end

    // Write pointers, frame length/overflow tracking, commit and rewind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            cmt_ptr_reg <= '0;
            cur_len_reg <= '0;
            ovf_reg     <= 1'b0;
            lq_wr_reg   <= '0;
        end else begin
            if (frame_end) begin
                cur_len_reg <= '0;
                ovf_reg     <= 1'b0;
            end else begin
                if (byte_ok && !cur_len_reg[16]) cur_len_reg <= cur_len_reg + 17'd1;
                if (bus.wr_valid && full_w) ovf_reg <= 1'b1;
            end
            if (drop_w) wr_ptr_reg <= cmt_ptr_reg;
            else        wr_ptr_reg <= wr_ptr_adv;
            if (commit_w) begin
                cmt_ptr_reg <= wr_ptr_adv;
                lq_wr_reg   <= lq_wr_reg + LQ_ONE;
            end
        end
    end

    // Drop pulse and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pulse_reg <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            drop_pulse_reg <= drop_w;
            if (drop_w && drop_count_reg != 16'hFFFF) drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

    // Committed-frame count; a simultaneous commit and pop cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frm_count_reg <= '0;
        else begin
            case ({commit_w, pop_w})
                2'b10:   frm_count_reg <= frm_count_reg + (LQ_W+1)'(1);
                2'b01:   frm_count_reg <= frm_count_reg - (LQ_W+1)'(1);
                default: frm_count_reg <= frm_count_reg;
            endcase
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Read datapath: remaining count, read pointer and length-queue pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg    <= '0;
            rd_ptr_reg <= '0;
            lq_rd_reg  <= '0;
        end else begin
            if (state_reg == IDLE && frm_count_reg != '0) rem_reg <= frm_len_w;
            if (accept) begin
                if (last_beat) begin
                    rd_ptr_reg <= rd_ptr_reg + POP_STEP;
                    lq_rd_reg  <= lq_rd_reg + LQ_ONE;
                end else begin
                    rd_ptr_reg <= rd_ptr_plus1;
                    rem_reg    <= rem_reg - 16'd1;
                end
            end
        end
    end

    // Hysteretic pause request from the registered fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pause_reg <= 1'b0;
        else if (used_w >= PAUSE_HI_LVL) pause_reg <= 1'b1;
        else if (used_w < PAUSE_LO_LVL)  pause_reg <= 1'b0;
    end

    assign bus.rd_data    = rd_data_reg;
    assign bus.rd_valid   = rd_valid_w;
    assign bus.rd_last    = rd_last_w;
    assign bus.frm_len    = frm_len_w;
    assign bus.frm_avail  = (frm_count_reg != '0);
    assign bus.frm_count  = frm_count_reg;
    assign bus.used       = used_w;
    assign bus.pause_req  = pause_reg;
    assign bus.drop_pulse = drop_pulse_reg;
    assign bus.drop_count = drop_count_reg;
endmodule

// File: tb/tb_frame_fifo.sv
// Directed bench for frame_fifo. Three instances share clk/rst:
// a = defaults without FCS strip, b = FCS strip, c = 64-entry RAM with
// low pause thresholds (32/16) for overflow and hysteresis checks.
module tb_frame_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    frame_fifo_if #(.DATA_W(8), .ADDR_W(11), .LQ_W(4)) if_a ();
    frame_fifo_if #(.DATA_W(8), .ADDR_W(11), .LQ_W(4)) if_b ();
    frame_fifo_if #(.DATA_W(8), .ADDR_W(6),  .LQ_W(4)) if_c ();

    frame_fifo #(.DATA_W(8), .ADDR_W(11), .LQ_W(4), .STRIP_FCS(0), .PAUSE_HI(1536), .PAUSE_LO(512))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    frame_fifo #(.DATA_W(8), .ADDR_W(11), .LQ_W(4), .STRIP_FCS(1), .PAUSE_HI(1536), .PAUSE_LO(512))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    frame_fifo #(.DATA_W(8), .ADDR_W(6), .LQ_W(4), .STRIP_FCS(0), .PAUSE_HI(32), .PAUSE_LO(16))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    logic [2:0][7:0]  wd = '0;
    logic [2:0]       wv = '0, wl = '0, wb = '0, rr = '0;
    logic [2:0][7:0]  q_data;
    logic [2:0]       q_valid, q_last, q_avail, q_pause, q_pulse;
    logic [2:0][15:0] q_len, q_dcnt, q_used;
    logic [2:0][4:0]  q_fcnt;

    assign if_a.wr_data = wd[0]; assign if_a.wr_valid = wv[0]; assign if_a.wr_last = wl[0];
    assign if_a.wr_bad  = wb[0]; assign if_a.rd_ready = rr[0];
    assign if_b.wr_data = wd[1]; assign if_b.wr_valid = wv[1]; assign if_b.wr_last = wl[1];
    assign if_b.wr_bad  = wb[1]; assign if_b.rd_ready = rr[1];
    assign if_c.wr_data = wd[2]; assign if_c.wr_valid = wv[2]; assign if_c.wr_last = wl[2];
    assign if_c.wr_bad  = wb[2]; assign if_c.rd_ready = rr[2];

    assign q_data[0] = if_a.rd_data;  assign q_data[1] = if_b.rd_data;  assign q_data[2] = if_c.rd_data;
    assign q_valid[0] = if_a.rd_valid; assign q_valid[1] = if_b.rd_valid; assign q_valid[2] = if_c.rd_valid;
    assign q_last[0] = if_a.rd_last;  assign q_last[1] = if_b.rd_last;  assign q_last[2] = if_c.rd_last;
    assign q_avail[0] = if_a.frm_avail; assign q_avail[1] = if_b.frm_avail; assign q_avail[2] = if_c.frm_avail;
    assign q_pause[0] = if_a.pause_req; assign q_pause[1] = if_b.pause_req; assign q_pause[2] = if_c.pause_req;
    assign q_pulse[0] = if_a.drop_pulse; assign q_pulse[1] = if_b.drop_pulse; assign q_pulse[2] = if_c.drop_pulse;
    assign q_len[0] = if_a.frm_len;   assign q_len[1] = if_b.frm_len;   assign q_len[2] = if_c.frm_len;
    assign q_dcnt[0] = if_a.drop_count; assign q_dcnt[1] = if_b.drop_count; assign q_dcnt[2] = if_c.drop_count;
    assign q_used[0] = 16'(if_a.used); assign q_used[1] = 16'(if_b.used); assign q_used[2] = 16'(if_c.used);
    assign q_fcnt[0] = if_a.frm_count; assign q_fcnt[1] = if_b.frm_count; assign q_fcnt[2] = if_c.frm_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One byte per clock; wr_bad is presented with the last byte.
    task automatic write_frame(input int s, input int n, input int start, input bit bad);
        for (int i = 0; i < n; i++) begin
            wd[s] = 8'(start + i);
            wv[s] = 1'b1;
            wl[s] = (i == n - 1);
            wb[s] = bad && (i == n - 1);
            tick();
        end
        wv[s] = 1'b0; wl[s] = 1'b0; wb[s] = 1'b0;
        $display("write inst=%0d len=%0d first=0x%02h bad=%0d", s, n, 8'(start), bad);
    endtask

    // Expects rd_ready already high; waits (bounded) for rd_valid then checks n beats.
    task automatic read_frame(input int s, input int n, input int start);
        int k = 0;
        while (!q_valid[s] && k < 8) begin
            tick();
            k++;
        end
        chk("rd_wait_valid", 32'(q_valid[s]), 32'd1);
        for (int i = 0; i < n; i++) begin
            chk("rd_beat", 32'({q_valid[s], q_last[s], q_data[s]}),
                32'({1'b1, (i == n - 1), 8'(start + i)}));
            tick();
        end
        $display("read  inst=%0d len=%0d first=0x%02h", s, n, 8'(start));
    endtask

    initial begin
        // Reset state, sampled while rst is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_data",   32'(q_data[0]),  32'd0);
        chk("rst_rd_valid",  32'(q_valid[0]), 32'd0);
        chk("rst_rd_last",   32'(q_last[0]),  32'd0);
        chk("rst_frm_len",   32'(q_len[0]),   32'd0);
        chk("rst_frm_avail", 32'(q_avail[0]), 32'd0);
        chk("rst_frm_count", 32'(q_fcnt[0]),  32'd0);
        chk("rst_used",      32'(q_used[0]),  32'd0);
        chk("rst_pause",     32'(q_pause[0]), 32'd0);
        chk("rst_drop_pls",  32'(q_pulse[0]), 32'd0);
        chk("rst_drop_cnt",  32'(q_dcnt[0]),  32'd0);
        rst = 1'b0;
        tick();

        // 64-byte good frame, no strip, consumer always ready.
        rr[0] = 1'b1;
        write_frame(0, 64, 8'h00, 1'b0);
        chk("t1_frm_len",   32'(q_len[0]),   32'd64);
        chk("t1_frm_count", 32'(q_fcnt[0]),  32'd1);
        chk("t1_frm_avail", 32'(q_avail[0]), 32'd1);
        chk("t1_valid_e0",  32'(q_valid[0]), 32'd0);
        tick();
        chk("t1_valid_e1",  32'(q_valid[0]), 32'd0);
        tick();
        chk("t1_valid_e2",  32'(q_valid[0]), 32'd1);
        read_frame(0, 64, 8'h00);
        chk("t1_frm_count_end", 32'(q_fcnt[0]),  32'd0);
        chk("t1_used_end",      32'(q_used[0]),  32'd0);
        chk("t1_valid_end",     32'(q_valid[0]), 32'd0);

        // FCS strip: 68 stored bytes, 64 presented; a 4-byte frame is dropped.
        rr[1] = 1'b1;
        write_frame(1, 68, 8'h00, 1'b0);
        chk("t2_frm_len", 32'(q_len[1]), 32'd64);
        read_frame(1, 64, 8'h00);
        chk("t2_used_end",  32'(q_used[1]),  32'd0);
        chk("t2_valid_end", 32'(q_valid[1]), 32'd0);
        tick();
        chk("t2_no_fcs_beats", 32'(q_valid[1]), 32'd0);
        write_frame(1, 4, 8'hC0, 1'b0);
        chk("t2_short_pulse", 32'(q_pulse[1]), 32'd1);
        chk("t2_short_cnt",   32'(q_dcnt[1]),  32'd1);
        chk("t2_short_used",  32'(q_used[1]),  32'd0);
        chk("t2_short_fcnt",  32'(q_fcnt[1]),  32'd0);
        tick();
        chk("t2_pulse_clear", 32'(q_pulse[1]), 32'd0);

        // Bad frame sandwiched between two good 10-byte frames.
        rr[0] = 1'b0;
        write_frame(0, 10, 8'h10, 1'b0);
        write_frame(0, 10, 8'hA0, 1'b1);
        chk("t3_bad_pulse", 32'(q_pulse[0]), 32'd1);
        chk("t3_bad_cnt",   32'(q_dcnt[0]),  32'd1);
        chk("t3_bad_used",  32'(q_used[0]),  32'd10);
        chk("t3_bad_fcnt",  32'(q_fcnt[0]),  32'd1);
        write_frame(0, 10, 8'h20, 1'b0);
        chk("t3_pulse_once", 32'(q_pulse[0]), 32'd0);
        chk("t3_fcnt2",      32'(q_fcnt[0]),  32'd2);
        chk("t3_used20",     32'(q_used[0]),  32'd20);
        rr[0] = 1'b1;
        read_frame(0, 10, 8'h10);
        read_frame(0, 10, 8'h20);
        repeat (3) tick();
        chk("t3_no_third",  32'(q_valid[0]), 32'd0);
        chk("t3_fcnt_end",  32'(q_fcnt[0]),  32'd0);
        chk("t3_cnt_end",   32'(q_dcnt[0]),  32'd1);
        chk("t3_used_end",  32'(q_used[0]),  32'd0);

        // 64-entry RAM: 40-byte frame commits, pause rises one clock after used>=32.
        rr[2] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wd[2] = 8'(i); wv[2] = 1'b1; wl[2] = (i == 39);
            tick();
            chk("t4_pause_fill", 32'(q_pause[2]), 32'(i >= 32));
        end
        wv[2] = 1'b0; wl[2] = 1'b0;
        $display("write inst=2 len=40 first=0x00 bad=0");
        chk("t4_f1_fcnt", 32'(q_fcnt[2]), 32'd1);
        chk("t4_f1_used", 32'(q_used[2]), 32'd40);
        // Second 40-byte frame overflows after 24 bytes and is rewound.
        write_frame(2, 40, 8'h80, 1'b0);
        chk("t4_ovf_pulse", 32'(q_pulse[2]), 32'd1);
        chk("t4_ovf_cnt",   32'(q_dcnt[2]),  32'd1);
        chk("t4_ovf_used",  32'(q_used[2]),  32'd40);
        chk("t4_ovf_fcnt",  32'(q_fcnt[2]),  32'd1);
        chk("t4_ovf_pause", 32'(q_pause[2]), 32'd1);
        // Drain: pause holds until used falls below 16.
        rr[2] = 1'b1;
        for (int j = 0; j < 40; j++) begin
            chk("t4_drain_beat", 32'({q_valid[2], q_last[2], q_data[2]}),
                32'({1'b1, (j == 39), 8'(j)}));
            chk("t4_pause_drain", 32'(q_pause[2]), 32'(j <= 25));
            tick();
        end
        $display("read  inst=2 len=40 first=0x00");
        repeat (3) tick();
        chk("t4_no_second", 32'(q_valid[2]), 32'd0);
        chk("t4_used_end",  32'(q_used[2]),  32'd0);
        chk("t4_pause_end", 32'(q_pause[2]), 32'd0);

        // Commit of B on the same edge as the pop of A keeps frm_count at 1.
        rr[0] = 1'b0;
        write_frame(0, 5, 8'h50, 1'b0);
        repeat (3) tick();
        chk("t5_stall_hold", 32'({q_valid[0], q_data[0]}), 32'({1'b1, 8'h50}));
        rr[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_a_beat", 32'({q_valid[0], q_last[0], q_data[0]}),
                32'({1'b1, (i == 4), 8'(8'h50 + i)}));
            chk("t5_fcnt_during", 32'(q_fcnt[0]), 32'd1);
            wd[0] = 8'(8'h60 + i); wv[0] = 1'b1; wl[0] = (i == 4);
            tick();
        end
        wv[0] = 1'b0; wl[0] = 1'b0;
        $display("b2b   inst=0 popA=0x50 commitB=0x60 len=5");
        chk("t5_fcnt_after", 32'(q_fcnt[0]), 32'd1);
        chk("t5_len_b",      32'(q_len[0]),  32'd5);
        chk("t5_used_b",     32'(q_used[0]), 32'd5);
        read_frame(0, 5, 8'h60);

        // Reset in the middle of a frame, with a committed frame pending.
        rr[0] = 1'b0;
        write_frame(0, 3, 8'h70, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wd[0] = 8'(8'h90 + i); wv[0] = 1'b1; wl[0] = 1'b0;
            tick();
        end
        chk("t6_pre_used", 32'(q_used[0]), 32'd6);
        rst = 1'b1;
        #2;
        chk("t6_rd_data",   32'(q_data[0]),  32'd0);
        chk("t6_rd_valid",  32'(q_valid[0]), 32'd0);
        chk("t6_frm_len",   32'(q_len[0]),   32'd0);
        chk("t6_frm_avail", 32'(q_avail[0]), 32'd0);
        chk("t6_frm_count", 32'(q_fcnt[0]),  32'd0);
        chk("t6_used",      32'(q_used[0]),  32'd0);
        chk("t6_drop_cnt",  32'(q_dcnt[0]),  32'd0);
        chk("t6_b_drop_cnt", 32'(q_dcnt[1]), 32'd0);
        wv = '0; wl = '0; wb = '0;
        rst = 1'b0;
        tick();
        tick();
        chk("t6_post_pulse", 32'(q_pulse[0]), 32'd0);
        chk("t6_post_used",  32'(q_used[0]),  32'd0);
        chk("t6_post_cnt",   32'(q_dcnt[0]),  32'd0);
        chk("t6_post_valid", 32'(q_valid[0]), 32'd0);
        $display("reset inst=0 mid-frame");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
